// File: rtl/sim_run_ctrl.sv
// Run controller for simulation tops: stretched core reset, cycle/retire counters,
// tohost/timeout/hang termination and sticky done/pass/fail status.
`timescale 1ns/1ps
module sim_run_ctrl #(
    parameter int              DW          = 32,
    parameter int              AW          = 32,
    parameter int              CW          = 32,
    parameter int              RST_HOLD    = 8,
    parameter int              TIMEOUT     = 20000,
    parameter int              HANG_LIMIT  = 256,
    parameter logic [AW-1:0]   TOHOST_ADDR = 32'h0000_1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    input  logic          retire_valid,
    output logic          core_rst,
    output logic          core_halt,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] retire_cnt,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout,
    output logic          hang,
    output logic [DW-1:0] result_code
);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_END} state_t;

    localparam logic [7:0]    HOLD_LAST    = 8'(RST_HOLD - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HANG_LAST    = CW'(HANG_LIMIT - 1);
    localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};

    state_t        state;
    logic [7:0]    hold_cnt;
    logic [CW-1:0] idle_cnt;

    logic tohost_hit;
    logic timeout_hit;
    logic hang_hit;

    // A zero-data store to tohost is an ordinary store, not a test end.
    assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != '0);
    assign timeout_hit = (TIMEOUT != 0) && (cycle_cnt == TIMEOUT_LAST);
    assign hang_hit    = (HANG_LIMIT != 0) && !retire_valid && (idle_cnt == HANG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            idle_cnt    <= '0;
            cycle_cnt   <= '0;
            retire_cnt  <= '0;
            core_rst    <= 1'b1;
            core_halt   <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            hang        <= 1'b0;
            result_code <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= S_RUN;
                        core_rst <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Counting still happens on the terminating edge.
                    if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
                    if (retire_valid && (retire_cnt != CNT_MAX)) retire_cnt <= retire_cnt + 1'b1;
                    if (retire_valid)               idle_cnt <= '0;
                    else if (idle_cnt != CNT_MAX)   idle_cnt <= idle_cnt + 1'b1;

                    if (tohost_hit) begin
                        state       <= S_END;
                        done        <= 1'b1;
                        core_halt   <= 1'b1;
                        result_code <= mem_wdata;
                        if (mem_wdata == DW'(1)) pass <= 1'b1;
                        else                     fail <= 1'b1;
                    end else if (timeout_hit) begin
                        state     <= S_END;
                        done      <= 1'b1;
                        core_halt <= 1'b1;
                        timeout   <= 1'b1;
                    end else if (hang_hit) begin
                        state     <= S_END;
                        done      <= 1'b1;
                        core_halt <= 1'b1;
                        hang      <= 1'b1;
                    end
                end
                S_END: begin
                    // Frozen until rst.
                end
                default: state <= S_HOLD;
            endcase
        end
    end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Parametrised run controller for simulation top levels; supersedes hand-coded reset/stop sequencing in benches.
- From the board-level reset, generates a stretched core reset with synchronous release.
- Counts cycles and retired instructions, detects the test-end store to a tohost address, and detects timeout and hang.
- Publishes sticky done/pass/fail status for the bench to sample and finish on.

Parameters:
- DW, 32, data width of the monitored store bus and of result_code
- AW, 32, address width of the monitored store bus
- CW, 32, width of cycle_cnt and retire_cnt
- RST_HOLD, 8, rising edges core_rst stays high after rst deasserts (legal range 1..255)
- TIMEOUT, 20000, RUN cycles before timeout (0 disables)
- HANG_LIMIT, 256, consecutive RUN cycles without a retire before hang (0 disables)
- TOHOST_ADDR, 32'h0000_1000, store address that terminates the test

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_we  in  1  data-store strobe, one store per cycle
- mem_addr  in  AW  store address
- mem_wdata  in  DW  store data
- retire_valid  in  1  one-cycle pulse per retired instruction
- core_rst  out  1  stretched reset to the core, active-high
- core_halt  out  1  high in END; the core clock-enable is gated on it
- cycle_cnt  out  CW  RUN cycle count
- retire_cnt  out  CW  retired instruction count
- done  out  1  test finished, sticky
- pass  out  1  finished with pass code
- fail  out  1  finished with fail code
- timeout  out  1  finished by TIMEOUT
- hang  out  1  finished by HANG_LIMIT
- result_code  out  DW  terminating store data

Behaviour:
- Async reset (rst=1, immediate, no clock needed):
  - state=HOLD, core_rst=1.
  - Hold, cycle, retire and idle counters = 0.
  - core_halt, done, pass, fail, timeout, hang = 0; result_code = 0.
- Reset asserted mid-RUN or in END returns everything to the above immediately.
- States: HOLD, RUN, END.
- HOLD:
  - Hold counter increments each edge.
  - On the edge where it equals RST_HOLD-1: state=RUN and core_rst falls (registered output, synchronous release).
  - core_rst is therefore high for exactly RST_HOLD edges after rst deasserts.
  - All bus inputs are ignored in HOLD.
- RUN, evaluated each edge:
  - cycle_cnt += 1.
  - retire_cnt += 1 when retire_valid=1.
  - Both counters saturate at all-ones (no wrap).
  - Idle counter clears on retire_valid, otherwise += 1; saturates.
- Termination conditions, highest priority first:
  1. Tohost store (mem_we=1, mem_addr==TOHOST_ADDR, mem_wdata!=0): END; result_code=mem_wdata; pass=1 if wdata==1, else fail=1.
  2. Timeout (TIMEOUT!=0 and cycle_cnt==TIMEOUT-1 before the increment): END; timeout=1.
  3. Hang (HANG_LIMIT!=0 and idle counter==HANG_LIMIT-1 with retire_valid=0): END; hang=1.
- Same-cycle conflicts: a tohost store wins. Exactly one of pass/fail/timeout/hang is set.
- Counting on the terminating edge: the cycle counter increments; a retire_valid on that edge is counted.
- A tohost store with wdata==0 is ignored (no termination) and is treated as an ordinary store.
- A store to any other address has no effect.
- END:
  - done=1 and core_halt=1 from the first edge in END.
  - Counters and status freeze; all inputs are ignored.
  - Only rst leaves END.
- All outputs are registered.
- Latency: status is visible the edge after the terminating input is sampled.

Test Plan:
1. Release sequence: RST_HOLD=8, rst high 195 ns then low, 20 ns clock -> core_rst falls on the 8th rising edge after release; cycle_cnt=0 at that point; 1 after the next edge.
2. Pass: after 100 RUN cycles, store 1 to 0x1000 -> next edge done=1, pass=1, result_code=1, cycle_cnt=101, core_halt=1. cycle_cnt stays 101 for 50 more cycles.
3. Fail plus priority: in the cycle where cycle_cnt==TIMEOUT-1, store 0x2A to 0x1000 -> fail=1, result_code=0x2A, timeout=0.
4. Zero and foreign stores: store 0 to 0x1000 and 5 to 0x1004 -> remain in RUN, done=0. With TIMEOUT=300 and retires continuing -> timeout=1, cycle_cnt=300.
5. Hang: HANG_LIMIT=16, retire_valid held low after 10 retires -> hang=1 on the 16th idle edge, retire_cnt=10. A retire on the 15th idle edge instead restarts the idle count.
6. Mid-run reset: assert rst between clock edges during RUN -> core_rst=1 and all counters 0 before the next edge. Full release sequence repeats on deassert.
